// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states,
// opcodes, ALU control codes and datapath mux selects.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_BR_LT  = 4'b0100;
    localparam logic [3:0] ALU_BR_LTU = 4'b0110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Immediate format implied by the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_src_of = IMM_S;
            OP_BRANCH: imm_src_of = IMM_B;
            OP_JAL:    imm_src_of = IMM_J;
            default:   imm_src_of = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface mc_controller_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       AdrSrc;
    logic       instr_done;
    logic [1:0] AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] Alu_Control;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instr_done,
        output AluSrcA, AluSrcB, ResultSrc, ImmSrc, Alu_Control, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, instr_done,
        input  AluSrcA, AluSrcB, ResultSrc, ImmSrc, Alu_Control, state
    );

endinterface

// File: rtl/mc_alu_ctrl.sv
// Combinational ALU-control decode driven by the controller state.
module mc_alu_ctrl
    import rv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       opcode_5,
    output logic [3:0] alu_control
);

    // Select the ALU operation for the current state.
    always_comb begin
        alu_control = ALU_ADD;
        case (state)
            S_BRANCH: begin
                if (funct3[2:1] == 2'b10)      alu_control = ALU_BR_LT;
                else if (funct3[2:1] == 2'b11) alu_control = ALU_BR_LTU;
                else                           alu_control = ALU_SUB;
            end
            S_EXECR, S_EXECI: begin
                // bit0 distinguishes sub from add (R-type only) and sra from srl.
                case (funct3)
                    3'b000:  alu_control = {funct3, funct7_5 & opcode_5};
                    3'b101:  alu_control = {funct3, funct7_5};
                    default: alu_control = {funct3, 1'b0};
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore-style multicycle RISC-V main controller: FSM, branch-taken logic
// and datapath control outputs.
module mc_controller
    import rv_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mc_controller_if.master  bus
);

    state_t     state_q, state_d;
    logic       taken;
    logic       pc_write, ir_write, mem_write, reg_write, instr_done;
    logic       adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Branch condition from funct3 and the ALU zero flag.
    always_comb begin
        taken = 1'b0;
        case (bus.funct3)
            3'b000, 3'b101, 3'b111: taken = bus.zero;
            3'b001, 3'b100, 3'b110: taken = ~bus.zero;
            default:                taken = 1'b0;
        endcase
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = '0;
        alu_src_b  = '0;
        result_src = '0;
        imm_src    = '0;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = imm_src_of(bus.opcode);
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                result_src = RES_ALUOUT;
                mem_write  = 1'b1;
                if (bus.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                result_src = RES_ALUOUT;
                pc_write   = taken;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mc_alu_ctrl u_alu_ctrl (
        .state       (state_q),
        .funct3      (bus.funct3),
        .funct7_5    (bus.funct7_5),
        .opcode_5    (bus.opcode[5]),
        .alu_control (alu_control)
    );

    // Write enables are forced low combinationally while reset is held,
    // since the state register only clears on the next edge.
    assign bus.PCWrite     = pc_write   & ~reset;
    assign bus.IRWrite     = ir_write   & ~reset;
    assign bus.MemWrite    = mem_write  & ~reset;
    assign bus.RegWrite    = reg_write  & ~reset;
    assign bus.instr_done  = instr_done & ~reset;
    assign bus.AdrSrc      = adr_src;
    assign bus.AluSrcA     = alu_src_a;
    assign bus.AluSrcB     = alu_src_b;
    assign bus.ResultSrc   = result_src;
    assign bus.ImmSrc      = imm_src;
    assign bus.Alu_Control = alu_control;
    assign bus.state       = state_q;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 One clock; reset is synchronous and active-high. Ports: clk in 1 (rising-edge clock); reset in 1 (synchronous, active-high).
REQ-002 Inputs: opcode in 7 (from IR); funct3 in 3; funct7_5 in 1; zero in 1 (ALU zero flag); mem_ready in 1 (memory access completes this cycle).
REQ-003 Write enables and status, all out 1: PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc (0=PC, 1=ALUOut), instr_done (one-cycle retire pulse).
REQ-004 Mux selects: AluSrcA out 2 (00=PC, 01=OldPC, 10=rs1); AluSrcB out 2 (00=rs2, 01=imm, 10=const 4); ResultSrc out 2 (00=ALUOut, 01=mem data, 10=ALU result).
REQ-005 Control and debug: ImmSrc out 3 (000=I, 001=S, 010=B, 011=J); Alu_Control out 4; state out 4 (debug).

Function
REQ-006 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10.
REQ-007 FETCH SHALL drive AdrSrc=0, AluSrcA=00, AluSrcB=10, ResultSrc=10, add. It SHALL hold until mem_ready=1, then pulse IRWrite=PCWrite=1 and move to DECODE.
REQ-008 DECODE SHALL drive AluSrcA=01, AluSrcB=01, add, and ImmSrc by opcode. It SHALL branch on opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other -> FETCH with instr_done=0.
REQ-009 MEMADR SHALL drive AluSrcA=10, AluSrcB=01, ImmSrc by opcode (I or S), add, then go to MEMREAD on a load or MEMWRITE on a store.
REQ-010 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, and hold until mem_ready, then go to MEMWB.
REQ-011 MEMWB SHALL drive ResultSrc=01, RegWrite=1, instr_done=1, then go to FETCH.
REQ-012 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, and MemWrite=1 continuously until mem_ready. On the mem_ready cycle it SHALL assert instr_done and go to FETCH.
REQ-013 EXECR SHALL drive AluSrcA=10, AluSrcB=00; EXECI SHALL drive AluSrcA=10, AluSrcB=01, ImmSrc=000. Both SHALL go to ALUWB.
REQ-014 ALUWB SHALL drive ResultSrc=00, RegWrite=1, instr_done=1, then go to FETCH.
REQ-015 BRANCH SHALL drive AluSrcA=10, AluSrcB=00, ResultSrc=00, PCWrite=taken, instr_done=1, then go to FETCH.
- Taken rule: funct3 000 -> zero; 001 -> !zero; 100/110 -> !zero; 101/111 -> zero; 010/011 -> 0.
REQ-016 JAL SHALL drive AluSrcA=01, AluSrcB=10, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-017 Alu_Control SHALL be ADD 0000 in FETCH, DECODE, MEMADR and JAL.
- BRANCH: 0100 if funct3[2:1]=10; 0110 if funct3[2:1]=11; else SUB 0001.
- EXECR/EXECI: {funct3, bit0}. bit0 = funct7_5 & opcode[5] for funct3=000; bit0 = funct7_5 for funct3=101; 0 otherwise.
REQ-018 Every output not listed for the current state SHALL be 0.
REQ-019 instr_done SHALL pulse exactly once per retired legal instruction.
REQ-020 mem_ready SHALL be ignored in all states except FETCH, MEMREAD and MEMWRITE.

Reset
REQ-021 reset=1 at a clock edge SHALL force state to FETCH from any state, including mid-MEMWRITE or mid-stall.
REQ-022 While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and instr_done SHALL be 0 regardless of state or mem_ready.
REQ-023 After reset, the remaining outputs SHALL take FETCH values (AluSrcB=10, ResultSrc=10, Alu_Control=0000, state=0).

Structure
REQ-024 Opcode constants, the state encoding and Alu_Control codes SHALL live in a shared package, rv_ctrl_pkg.
REQ-025 ALU-control decode SHALL be one combinational sub-module, mc_alu_ctrl; the FSM and the taken logic SHALL stay in mc_controller.

Verification
REQ-026 add x3,x1,x2 (0110011, f3 000, f7_5=0), mem_ready=1 -> states 0,1,6,8,0; Alu_Control=0000 in EXECR; RegWrite=1 in ALUWB only; 4 cycles per instruction.
REQ-027 sw (0100011), mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; instr_done on the 4th; no RegWrite.
REQ-028 beq with zero=1 -> PCWrite=1 in BRANCH, Alu_Control=0001. bltu with zero=1 -> PCWrite=0, Alu_Control=0110.
REQ-029 srai (0010011, f3 101, f7_5=1) -> Alu_Control=1011. addi with f7_5=1 -> Alu_Control=0000.
REQ-030 reset asserted during a MEMREAD stall -> next cycle state=0 with all enables 0. Opcode 1111111 in DECODE -> returns to FETCH, no instr_done.
